// File: rtl/key_fifo_pkg.sv
// Shared types and helpers for the keyboard FIFO with typematic repeat.
package key_fifo_pkg;

    // Typematic key states: no key, waiting out the initial delay, auto-repeating.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } typ_state_t;

    localparam int DEPTH_DEFAULT = 64;

    // Pointer width for a power-of-two FIFO: index bits plus one wrap bit.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/key_typematic.sv
// Typematic engine: detects key presses and generates auto-repeat pushes.
// All state advances only on key_sample; push is combinational so the
// FIFO captures the key in the same clock as the decision.
module key_typematic
    import key_fifo_pkg::*;
#(
    parameter int DW           = 8,
    parameter int REPEAT_DELAY = 300000,
    parameter int REPEAT_RATE  = 30000,
    parameter int CW           = 19
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          key_sample,
    input  logic [DW-1:0] ascii_key,
    output logic          push,
    output logic [DW-1:0] push_data
);

    localparam logic [CW-1:0] DELAY_TERM = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] RATE_TERM  = CW'(REPEAT_RATE - 1);

    typ_state_t    state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [DW-1:0] prev, prev_nxt;
    logic [CW-1:0] cnt_term;

    // State, repeat counter and last-pushed key register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            prev  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            prev  <= prev_nxt;
        end
    end

    // Next-state decision and push generation, gated by the scan strobe.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        prev_nxt  = prev;
        push      = 1'b0;
        push_data = ascii_key;
        cnt_term  = (state == REPEAT) ? RATE_TERM : DELAY_TERM;
        if (key_sample) begin
            case (state)
                IDLE: begin
                    if (ascii_key != '0) begin
                        push      = 1'b1;
                        prev_nxt  = ascii_key;
                        cnt_nxt   = '0;
                        state_nxt = DELAY;
                    end
                end
                DELAY, REPEAT: begin
                    if (ascii_key == '0) begin
                        cnt_nxt   = '0;
                        state_nxt = IDLE;
                    end else if (ascii_key != prev) begin
                        push      = 1'b1;
                        prev_nxt  = ascii_key;
                        cnt_nxt   = '0;
                        state_nxt = DELAY;
                    end else if (cnt == cnt_term) begin
                        push      = 1'b1;
                        push_data = prev;
                        cnt_nxt   = '0;
                        state_nxt = REPEAT;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
                default: begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/key_fifo_rpt.sv
// Keyboard character FIFO with typematic auto-repeat and status flags.
// Optional build macro KEY_FIFO_DROP_OLDEST_EN: a push into a full FIFO
// overwrites the oldest entry instead of discarding the new key.
module key_fifo_rpt
    import key_fifo_pkg::*;
#(
    parameter int DW           = 8,
    parameter int DEPTH        = DEPTH_DEFAULT,
    parameter int REPEAT_DELAY = 300000,
    parameter int REPEAT_RATE  = 30000,
    parameter int CW           = 19
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   key_sample,
    input  logic [DW-1:0]          ascii_key,
    input  logic                   rd_en,
    output logic [DW-1:0]          rd_data,
    output logic                   rd_valid,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    input  logic                   ovf_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = ptr_width(DEPTH);

    logic          push;
    logic [DW-1:0] push_data;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [DW-1:0] mem [DEPTH];
    logic          do_pop, do_write, ovf_event, drop_adv, rd_adv;

    key_typematic #(
        .DW          (DW),
        .REPEAT_DELAY(REPEAT_DELAY),
        .REPEAT_RATE (REPEAT_RATE),
        .CW          (CW)
    ) u_typematic (
        .clk       (clk),
        .rst       (rst),
        .key_sample(key_sample),
        .ascii_key (ascii_key),
        .push      (push),
        .push_data (push_data)
    );

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign count = wr_ptr - rd_ptr;

    assign do_pop    = rd_en & ~empty;
    assign ovf_event = push & full & ~do_pop;

`ifdef KEY_FIFO_DROP_OLDEST_EN
    assign do_write = push;
    assign drop_adv = ovf_event;
`else
    assign do_write = push & (~full | do_pop);
    assign drop_adv = 1'b0;
`endif

    assign rd_adv = do_pop | drop_adv;

    // Character storage; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    // Write and read pointers, each with an extra wrap bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_write) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (rd_adv) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    // Registered read port; an empty pop returns zero with no valid flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else if (rd_en) begin
            if (!empty) begin
                rd_data  <= mem[rd_ptr[AW-1:0]];
                rd_valid <= 1'b1;
            end else begin
                rd_data  <= '0;
                rd_valid <= 1'b0;
            end
        end else begin
            rd_valid <= 1'b0;
        end
    end

    // Sticky overflow flag; a new loss outranks a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (ovf_event) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_key_fifo_rpt.sv
// Directed testbench for key_fifo_rpt with DEPTH=4, REPEAT_DELAY=4, REPEAT_RATE=2.
module tb_key_fifo_rpt;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_sample = 1'b0;
    logic [7:0] ascii_key = 8'h00;
    logic       rd_en = 1'b0;
    logic       ovf_clr = 1'b0;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       empty;
    logic       full;
    logic [2:0] count;
    logic       overflow;

    int errors = 0;
    int checks = 0;

`ifdef KEY_FIFO_DROP_OLDEST_EN
    localparam bit DROP = 1'b1;
`else
    localparam bit DROP = 1'b0;
`endif

    int holdCount [10] = '{1, 1, 1, 1, 2, 2, 3, 3, 4, 4};

    key_fifo_rpt #(
        .DW          (8),
        .DEPTH       (4),
        .REPEAT_DELAY(4),
        .REPEAT_RATE (2),
        .CW          (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key_sample(key_sample),
        .ascii_key (ascii_key),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .empty     (empty),
        .full      (full),
        .count     (count),
        .overflow  (overflow),
        .ovf_clr   (ovf_clr)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Drive one cycle of inputs, then settle just after the rising edge.
    task automatic applyStimulus(input logic [7:0] key, input logic smp,
                                 input logic rd, input logic clr);
        ascii_key  = key;
        key_sample = smp;
        rd_en      = rd;
        ovf_clr    = clr;
        @(posedge clk);
        #1;
    endtask

    // Compare one observed value with its expected value.
    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Linear directed sequence.
    initial begin
        logic [7:0] base;

        applyStimulus(8'h00, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'h00, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        checkOutput("rst_rd_data", 32'(rd_data), 0);
        checkOutput("rst_rd_valid", 32'(rd_valid), 0);
        checkOutput("rst_overflow", 32'(overflow), 0);
        checkOutput("rst_count", 32'(count), 0);
        checkOutput("rst_empty", 32'(empty), 1);
        checkOutput("rst_full", 32'(full), 0);

        // Key present without a strobe must be ignored.
        applyStimulus(8'h55, 1'b0, 1'b0, 1'b0);
        checkOutput("nostrobe_count", 32'(count), 0);
        applyStimulus(8'h00, 1'b1, 1'b0, 1'b0);

        // Tap and read back.
        $display("[TB] tap");
        applyStimulus(8'h41, 1'b1, 1'b0, 1'b0);
        applyStimulus(8'h00, 1'b1, 1'b0, 1'b0);
        checkOutput("tap_count", 32'(count), 1);
        checkOutput("tap_empty", 32'(empty), 0);
        applyStimulus(8'h00, 1'b1, 1'b1, 1'b0);
        checkOutput("tap_rd_data", 32'(rd_data), 32'h41);
        checkOutput("tap_rd_valid", 32'(rd_valid), 1);
        checkOutput("tap_empty_after", 32'(empty), 1);
        applyStimulus(8'h00, 1'b1, 1'b0, 1'b0);
        checkOutput("tap_valid_drop", 32'(rd_valid), 0);
        checkOutput("tap_data_hold", 32'(rd_data), 32'h41);

        // Hold: pushes at samples 1, 5, 7, 9.
        $display("[TB] hold");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(8'h61, 1'b1, 1'b0, 1'b0);
            checkOutput($sformatf("hold_s%0d_count", i + 1), 32'(count), 32'(holdCount[i]));
        end
        checkOutput("hold_full", 32'(full), 1);
        checkOutput("hold_overflow", 32'(overflow), 0);
        applyStimulus(8'h00, 1'b1, 1'b0, 1'b0);

        // Full FIFO with tap and pop together.
        $display("[TB] full concurrency");
        applyStimulus(8'h41, 1'b1, 1'b1, 1'b0);
        checkOutput("fullcc_count", 32'(count), 4);
        checkOutput("fullcc_overflow", 32'(overflow), 0);
        checkOutput("fullcc_rd_data", 32'(rd_data), 32'h61);
        checkOutput("fullcc_rd_valid", 32'(rd_valid), 1);
        applyStimulus(8'h00, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(8'h00, 1'b1, 1'b1, 1'b0);
            checkOutput($sformatf("fullcc_drain%0d", i), 32'(rd_data), (i == 3) ? 32'h41 : 32'h61);
        end
        checkOutput("fullcc_empty", 32'(empty), 1);

        // Empty FIFO with tap and pop together: no bypass.
        $display("[TB] empty concurrency");
        applyStimulus(8'h42, 1'b1, 1'b1, 1'b0);
        checkOutput("emptycc_rd_data", 32'(rd_data), 0);
        checkOutput("emptycc_rd_valid", 32'(rd_valid), 0);
        checkOutput("emptycc_count", 32'(count), 1);
        applyStimulus(8'h00, 1'b1, 1'b1, 1'b0);
        checkOutput("emptycc_pop_data", 32'(rd_data), 32'h42);
        checkOutput("emptycc_pop_valid", 32'(rd_valid), 1);

        // Rollover: key change pushes at once and restarts the delay.
        $display("[TB] rollover");
        applyStimulus(8'h61, 1'b1, 1'b0, 1'b0);
        applyStimulus(8'h61, 1'b1, 1'b0, 1'b0);
        checkOutput("roll_s2_count", 32'(count), 1);
        applyStimulus(8'h62, 1'b1, 1'b0, 1'b0);
        checkOutput("roll_s3_count", 32'(count), 2);
        for (int i = 0; i < 3; i++) applyStimulus(8'h62, 1'b1, 1'b0, 1'b0);
        checkOutput("roll_s6_count", 32'(count), 2);
        applyStimulus(8'h62, 1'b1, 1'b0, 1'b0);
        checkOutput("roll_s7_count", 32'(count), 3);
        applyStimulus(8'h00, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(8'h00, 1'b1, 1'b1, 1'b0);
            checkOutput($sformatf("roll_drain%0d", i), 32'(rd_data), (i == 0) ? 32'h61 : 32'h62);
        end

        // Overflow with five taps and no reads.
        $display("[TB] overflow");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(8'h31 + 8'(i), 1'b1, 1'b0, 1'b0);
            applyStimulus(8'h00, 1'b1, 1'b0, 1'b0);
            if (i == 3) checkOutput("ovf_not_yet", 32'(overflow), 0);
        end
        checkOutput("ovf_set", 32'(overflow), 1);
        checkOutput("ovf_count", 32'(count), 4);
        base = DROP ? 8'h32 : 8'h31;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(8'h00, 1'b1, 1'b1, 1'b0);
            checkOutput($sformatf("ovf_read%0d", i), 32'(rd_data), 32'(base + 8'(i)));
        end
        checkOutput("ovf_sticky", 32'(overflow), 1);
        applyStimulus(8'h00, 1'b1, 1'b0, 1'b1);
        checkOutput("ovf_clr", 32'(overflow), 0);

        // Clear coinciding with a new overflow: set wins.
        $display("[TB] clear vs set");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(8'h41 + 8'(i), 1'b1, 1'b0, 1'b0);
            applyStimulus(8'h00, 1'b1, 1'b0, 1'b0);
        end
        applyStimulus(8'h45, 1'b1, 1'b0, 1'b1);
        checkOutput("clrset_overflow", 32'(overflow), 1);
        applyStimulus(8'h00, 1'b1, 1'b0, 1'b1);
        checkOutput("clrset_cleared", 32'(overflow), 0);
        base = DROP ? 8'h42 : 8'h41;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(8'h00, 1'b1, 1'b1, 1'b0);
            checkOutput($sformatf("clrset_read%0d", i), 32'(rd_data), 32'(base + 8'(i)));
        end

        // Reset while in REPEAT with 0x7A held.
        $display("[TB] reset mid-hold");
        for (int i = 0; i < 6; i++) applyStimulus(8'h7A, 1'b1, 1'b0, 1'b0);
        checkOutput("rsthold_pre_count", 32'(count), 2);
        rst = 1'b1;
        applyStimulus(8'h7A, 1'b1, 1'b0, 1'b0);
        checkOutput("rsthold_count", 32'(count), 0);
        checkOutput("rsthold_empty", 32'(empty), 1);
        checkOutput("rsthold_rd_data", 32'(rd_data), 0);
        checkOutput("rsthold_overflow", 32'(overflow), 0);
        rst = 1'b0;
        applyStimulus(8'h7A, 1'b1, 1'b0, 1'b0);
        checkOutput("rsthold_repush", 32'(count), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/key_fifo_rpt.md
Name: key_fifo_rpt

Overview:
Parametrised successor to the keyboard character buffer. Single-clock design.
- Samples the decoded ASCII key on a scan strobe.
- Generates typematic auto-repeat: initial delay, then a fixed repeat rate.
- Queues characters in a power-of-two FIFO that the CPU pops with a registered read port.
- Adds occupancy, full/empty and sticky overflow status.

Parameters:
DW, 8, key code width in bits
DEPTH, 64, FIFO entries; power of two, minimum 2
REPEAT_DELAY, 300000, key_sample ticks a key is held before the first repeat
REPEAT_RATE, 30000, key_sample ticks between subsequent repeats
CW, 19, repeat counter width; must hold max(REPEAT_DELAY, REPEAT_RATE)

Ports:
clk  in  1  system clock; all logic on posedge
rst  in  1  synchronous, active-high reset
key_sample  in  1  one-cycle scan strobe; key logic advances only on this strobe
ascii_key  in  DW  current decoded key; 0 means no key held
rd_en  in  1  CPU pop request
rd_data  out  DW  popped character (registered)
rd_valid  out  1  rd_data was loaded from the FIFO this cycle
empty  out  1  FIFO holds 0 entries
full  out  1  FIFO holds DEPTH entries
count  out  $clog2(DEPTH)+1  current occupancy
overflow  out  1  sticky; a push was lost (or overwrote data)
ovf_clr  in  1  clears overflow

Behaviour:
Reset and status
- Reset values: rd_data=0, rd_valid=0, overflow=0, count=0, empty=1, full=0; FSM in IDLE; repeat counter=0; prev=0. RAM contents are not reset.
- Reset mid-hold: FSM returns to IDLE. A key still held at the next key_sample is treated as a new press and pushed.
- Pointers wr_ptr and rd_ptr carry one extra wrap bit. empty = pointers equal. full = index bits equal and wrap bits differ. count = wr_ptr - rd_ptr. All three are combinational from registered pointers.

Typematic FSM (evaluated only when key_sample=1; otherwise holds all state)
- IDLE: ascii_key!=0 -> push ascii_key, prev<=ascii_key, cnt<=0, go to DELAY. ascii_key==0 -> stay.
- DELAY: ascii_key==0 -> IDLE. ascii_key!=prev -> push the new key, prev<=ascii_key, cnt<=0, stay in DELAY. cnt==REPEAT_DELAY-1 -> push prev, cnt<=0, go to REPEAT. Otherwise cnt<=cnt+1.
- REPEAT: identical to DELAY, but the terminal value is REPEAT_RATE-1 and the state stays REPEAT on expiry. A key change returns the FSM to DELAY.

Push
- The push strobe reaches the RAM in the same clk cycle as the FSM decision.
- Not full: mem[wr_ptr]<=key; wr_ptr++.
- Full, no simultaneous pop: key discarded; overflow<=1.

Pop
- rd_en=1 and not empty: rd_data<=mem[rd_ptr], rd_valid<=1, rd_ptr++. Data appears one cycle after rd_en.
- rd_en=1 and empty: rd_data<=0, rd_valid<=0.
- rd_en=0: rd_valid<=0; rd_data holds its value.

Simultaneous events
- Push and pop while full: both succeed; count unchanged; no overflow.
- Push and pop while empty: pop returns 0 with rd_valid=0 (no bypass path); the push is stored; count becomes 1.
- ovf_clr together with a new overflow event in the same cycle: set wins; overflow stays 1.

Optional Feature:
KEY_FIFO_DROP_OLDEST_EN
- Defined: a push into a full FIFO with no simultaneous pop writes mem[wr_ptr] and advances both wr_ptr and rd_ptr. The oldest entry is lost, the newest is kept, count stays DEPTH, and overflow<=1.
- Undefined: the newest key is dropped, as specified under Push.

Decomposition:
- Package key_fifo_pkg: typematic state enum (IDLE, DELAY, REPEAT) and a pointer-width helper constant derived from DEPTH.
- Sub-module key_typematic: the FSM plus repeat counter. Outputs push and push_data. Top level key_fifo_rpt holds the RAM, pointers, flags and read port.

Test Plan:
(Parameters: DEPTH=4, REPEAT_DELAY=4, REPEAT_RATE=2, key_sample every cycle unless stated.)
- Tap: ascii_key=0x41 for 1 sample, then 0 -> count=1. Then rd_en for 1 cycle -> next cycle rd_data=0x41, rd_valid=1, empty=1.
- Hold: 0x61 held for 10 samples -> pushes at samples 1, 5, 7 and 9. The 4th push fills the FIFO: count=4, full=1, overflow=0.
- Rollover: 0x61 held 2 samples, then 0x62 -> 0x62 pushed immediately and the delay restarts (next 0x62 push 4 samples later).
- Overflow: 5 taps 0x31..0x35 with no reads -> overflow=1. Default build reads back 0x31..0x34; KEY_FIFO_DROP_OLDEST_EN build reads back 0x32..0x35. Then ovf_clr -> overflow=0.
- Concurrency: full FIFO + tap + rd_en in the same cycle -> count stays 4, no overflow. Empty FIFO + tap + rd_en -> rd_data=0, rd_valid=0, count=1.
- Reset mid-hold: rst asserted during REPEAT with 0x7A held -> all outputs at reset values; first sample after reset pushes 0x7A, count=1.
